// File: rtl/gmux_sel_pkg.sv
// Shared types and widths for the glitch-free clock mux select controller.
// Pure declarations: no logic, no latency, no flow control.
package gmux_sel_pkg;

  localparam int CNT_W = 8;
  localparam int SWC_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE_OFF,
    ST_SWITCH,
    ST_GATE_ON,
    ST_ACK
  } state_t;

endpackage

// File: rtl/gmux_dly_cnt.sv
// Loadable down-counter with zero flag; load takes effect on the next edge.
// Stops at zero until reloaded; no flow control.
module gmux_dly_cnt
  import gmux_sel_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gmux_sel_ctrl.sv
// Sequences a clock-mux select change: gate off, switch, settle, gate on; Q+S+1 cycles to done.
// One request in flight; req_ready is low from accept until the sequence returns to idle.
module gmux_sel_ctrl
  import gmux_sel_pkg::*;
#(
  parameter int QUIET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter bit INIT_SEL      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_sel,
  output logic             req_ready,
  output logic             is0,
  output logic             gate_en,
  output logic             busy,
  output logic             done,
  output logic [SWC_W-1:0] sw_count
);

  localparam logic [CNT_W-1:0] QUIET_LD  = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic             sel_q;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  assign accept = req_valid & req_ready;

  gmux_dly_cnt u_dly_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_sel != is0) begin
            state_nxt = ST_GATE_OFF;
            cnt_load  = 1'b1;
            cnt_val   = QUIET_LD;
          end else begin
            state_nxt = ST_ACK;
          end
        end
      end
      ST_GATE_OFF: begin
        if (cnt_zero) begin
          state_nxt = ST_SWITCH;
          cnt_load  = 1'b1;
          cnt_val   = SETTLE_LD;
        end
      end
      ST_SWITCH: begin
        if (cnt_zero) state_nxt = ST_GATE_ON;
      end
      ST_GATE_ON, ST_ACK: state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so every port comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel_q     <= INIT_SEL;
      is0       <= INIT_SEL;
      gate_en   <= 1'b1;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      sw_count  <= '0;
    end else begin
      state     <= state_nxt;
      if (accept) sel_q <= req_sel;
      if (state == ST_GATE_OFF && state_nxt == ST_SWITCH) is0 <= sel_q;
      gate_en   <= !(state_nxt == ST_GATE_OFF || state_nxt == ST_SWITCH);
      req_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_GATE_ON || state_nxt == ST_ACK);
      if (state_nxt == ST_GATE_ON && sw_count != '1) sw_count <= sw_count + SWC_W'(1);
    end
  end

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Scoreboard bench: stimulus pushes expected done events, a negedge monitor pops and compares.
// Two instances cover default timing (Q=S=4, INIT_SEL=0) and minimum timing (Q=S=1, INIT_SEL=1).
module tb_gmux_sel_ctrl;

  typedef struct {
    int   cyc;
    logic is0;
    int   swc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid_a = 1'b0, req_sel_a = 1'b0;
  logic       req_valid_b = 1'b0, req_sel_b = 1'b0;
  logic       req_ready_a, is0_a, gate_en_a, busy_a, done_a;
  logic       req_ready_b, is0_b, gate_en_b, busy_b, done_b;
  logic [7:0] sw_count_a, sw_count_b;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic m_is0_a = 1'b0;
  int   m_swc_a = 0;

  gmux_sel_ctrl #(.QUIET_CYCLES(4), .SETTLE_CYCLES(4), .INIT_SEL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_sel(req_sel_a),
    .req_ready(req_ready_a), .is0(is0_a), .gate_en(gate_en_a), .busy(busy_a),
    .done(done_a), .sw_count(sw_count_a)
  );

  gmux_sel_ctrl #(.QUIET_CYCLES(1), .SETTLE_CYCLES(1), .INIT_SEL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_sel(req_sel_b),
    .req_ready(req_ready_b), .is0(is0_b), .gate_en(gate_en_b), .busy(busy_b),
    .done(done_b), .sw_count(sw_count_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic to_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Holds the request until accepted, then records the expected done event.
  task automatic req_a(input logic sel, output int acc);
    int n = 0;
    exp_t e;
    req_valid_a = 1'b1;
    req_sel_a   = sel;
    while (!req_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("req_a_accept_timeout", 0, 1);
      req_valid_a = 1'b0;
      acc = cyc;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid_a = 1'b0;
    if (sel != m_is0_a) begin
      m_is0_a = sel;
      if (m_swc_a < 255) m_swc_a++;
      e.cyc = acc + 8;
    end else begin
      e.cyc = acc;
    end
    e.is0 = m_is0_a;
    e.swc = m_swc_a;
    qa.push_back(e);
  endtask

  // Monitor: done events and the select-stable-while-gated invariant.
  logic prev_is0_a = 1'b0, prev_ge_a = 1'b1, prev_is0_b = 1'b1, prev_ge_b = 1'b1, prev_rst = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done_a) begin
        if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_done_cycle", cyc, e.cyc);
          chk("a_done_is0", int'(is0_a), int'(e.is0));
          chk("a_done_swcount", int'(sw_count_a), e.swc);
          chk("a_done_gate_en", int'(gate_en_a), 1);
        end
      end
      if (done_b) begin
        if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_done_cycle", cyc, e.cyc);
          chk("b_done_is0", int'(is0_b), int'(e.is0));
          chk("b_done_swcount", int'(sw_count_b), e.swc);
        end
      end
      if (prev_rst && is0_a != prev_is0_a)
        chk("a_is0_change_while_gated", int'(gate_en_a | prev_ge_a), 0);
      if (prev_rst && is0_b != prev_is0_b)
        chk("b_is0_change_while_gated", int'(gate_en_b | prev_ge_b), 0);
    end
    prev_is0_a = is0_a;
    prev_ge_a  = gate_en_a;
    prev_is0_b = is0_b;
    prev_ge_b  = gate_en_b;
    prev_rst   = rst_n;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    exp_t e;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_is0", int'(is0_a), 0);
    chk("rst_a_gate_en", int'(gate_en_a), 1);
    chk("rst_a_ready", int'(req_ready_a), 1);
    chk("rst_a_busy", int'(busy_a), 0);
    chk("rst_a_done", int'(done_a), 0);
    chk("rst_a_swcount", int'(sw_count_a), 0);
    chk("rst_b_is0", int'(is0_b), 1);
    rst_n = 1'b1;

    // Minimum timing instance: 1 -> 0
    @(negedge clk);
    req_valid_b = 1'b1;
    req_sel_b   = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid_b = 1'b0;
    e.cyc = acc + 2; e.is0 = 1'b0; e.swc = 1;
    qb.push_back(e);
    to_cyc(acc);
    chk("b_c1_gate_en", int'(gate_en_b), 0);
    chk("b_c1_is0", int'(is0_b), 1);
    to_cyc(acc + 1);
    chk("b_c2_gate_en", int'(gate_en_b), 0);
    chk("b_c2_is0", int'(is0_b), 0);
    to_cyc(acc + 2);
    chk("b_c3_gate_en", int'(gate_en_b), 1);
    to_cyc(acc + 3);
    chk("b_c4_ready", int'(req_ready_b), 1);

    // Default timing: 0 -> 1 full profile
    req_a(1'b1, acc);
    for (int k = 1; k <= 8; k++) begin
      to_cyc(acc + k - 1);
      chk("a_sw_gate_en_off", int'(gate_en_a), 0);
      chk("a_sw_is0", int'(is0_a), (k >= 5) ? 1 : 0);
      chk("a_sw_ready", int'(req_ready_a), 0);
    end
    to_cyc(acc + 8);
    chk("a_c9_gate_en", int'(gate_en_a), 1);
    to_cyc(acc + 9);
    chk("a_c10_ready", int'(req_ready_a), 1);

    // Same-select request: ack only
    req_a(1'b1, acc);
    to_cyc(acc);
    chk("a_ack_gate_en", int'(gate_en_a), 1);
    to_cyc(acc + 1);
    chk("a_ack_is0", int'(is0_a), 1);
    chk("a_ack_swcount", int'(sw_count_a), 1);
    chk("a_ack_ready", int'(req_ready_a), 1);

    // Held valid with toggling select while busy
    req_a(1'b0, acc);
    req_valid_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      to_cyc(acc + k - 1);
      req_sel_a = k[0];
      chk("a_hold_busy", int'(busy_a), 1);
      chk("a_hold_ready", int'(req_ready_a), 0);
    end
    to_cyc(acc + 8);
    req_valid_a = 1'b0;
    to_cyc(acc + 9);
    chk("a_hold_is0", int'(is0_a), 0);
    chk("a_hold_pending", qa.size(), 0);

    // Reset in cycle 6 of a 0 -> 1 switch
    req_a(1'b1, acc);
    to_cyc(acc + 5);
    chk("a_pre_abort_is0", int'(is0_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_abort_is0", int'(is0_a), 0);
    chk("a_abort_gate_en", int'(gate_en_a), 1);
    chk("a_abort_done", int'(done_a), 0);
    chk("a_abort_busy", int'(busy_a), 0);
    chk("a_abort_swcount", int'(sw_count_a), 0);
    qa.delete();
    m_is0_a = 1'b0;
    m_swc_a = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release accepts
    req_a(1'b1, acc);
    chk("a_first_edge_busy", int'(busy_a), 1);

    // Saturation over 260 alternating switches
    for (int i = 0; i < 260; i++) req_a(~m_is0_a, acc);
    to_cyc(acc + 9);
    chk("a_sat_swcount", int'(sw_count_a), 255);
    chk("a_sat_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
